// File: rtl/password_checker_if.sv
// Keypad-side and indicator-side signals of the password checker.
// The keypad/bench drives through master; the checker itself takes slave.
interface password_checker_if #(
  parameter int DIGIT_W = 3
);
  logic [DIGIT_W-1:0] data;
  logic               dk;
  logic               prog;
  logic               relock;
  logic               locked;
  logic               unlocked;
  logic               alarm;
  logic [2:0]         digit_cnt;
  logic [1:0]         fail_cnt;

  modport master (
    output data, dk, prog, relock,
    input  locked, unlocked, alarm, digit_cnt, fail_cnt
  );

  modport slave (
    input  data, dk, prog, relock,
    output locked, unlocked, alarm, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/password_checker.sv
// Checks keypad digit sequences against a stored password, counts failures,
// runs a timed alarm lockout and lets the password be reprogrammed while open.
//
// state       | meaning
// ST_LOCKED   | collecting an entry attempt, lock engaged
// ST_UNLOCKED | open; prog digits build a new password, relock closes
// ST_ALARM    | too many failures, all input ignored until lockout expires
module password_checker #(
  parameter int                           DIGIT_W        = 3,
  parameter int                           PW_LEN         = 4,
  parameter logic [PW_LEN*DIGIT_W-1:0]    DEFAULT_PW     = 12'b001_010_011_100,
  parameter int                           MAX_TRIES      = 3,
  parameter int                           LOCKOUT_CYCLES = 4000000,
  parameter int                           ENTRY_TIMEOUT  = 2000000
) (
  input logic                clk,
  input logic                reset,
  password_checker_if.slave  bus
);

  localparam int PW_W   = PW_LEN * DIGIT_W;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int IDLE_W = (ENTRY_TIMEOUT > 2) ? $clog2(ENTRY_TIMEOUT) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(ENTRY_TIMEOUT - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(PW_LEN - 1);
  localparam logic [2:0]        MAX_F     = 3'(MAX_TRIES);

  // Encoding doubles as the output decode: bit0 locked, bit1 unlocked, bit2 alarm.
  typedef enum logic [2:0] {
    ST_LOCKED   = 3'b001,
    ST_UNLOCKED = 3'b010,
    ST_ALARM    = 3'b101
  } state_e;

  state_e              state_q, state_d;
  logic [PW_W-1:0]     pw_q, pw_d;
  logic [PW_W-1:0]     shadow_q, shadow_d;
  logic [2:0]          digit_cnt_q, digit_cnt_d;
  logic [1:0]          fail_cnt_q, fail_cnt_d;
  logic                mismatch_q, mismatch_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;

  logic [DIGIT_W-1:0]  cur_digit;
  logic [PW_W-1:0]     shadow_wr;
  logic                miss_now;
  logic                last_digit;
  logic                idle_expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOCKED;
      pw_q        <= DEFAULT_PW;
      shadow_q    <= '0;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      idle_q      <= '0;
      lock_q      <= '0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      shadow_q    <= shadow_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      mismatch_q  <= mismatch_d;
      idle_q      <= idle_d;
      lock_q      <= lock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    shadow_d    = shadow_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    mismatch_d  = mismatch_q;
    idle_d      = idle_q;
    lock_d      = lock_q;

    cur_digit = pw_q[(PW_LEN - 1 - int'(digit_cnt_q)) * DIGIT_W +: DIGIT_W];
    shadow_wr = shadow_q;
    shadow_wr[(PW_LEN - 1 - int'(digit_cnt_q)) * DIGIT_W +: DIGIT_W] = bus.data;
    miss_now     = mismatch_q | (bus.data != cur_digit);
    last_digit   = (digit_cnt_q == LAST_IDX);
    idle_expired = (digit_cnt_q != 3'd0) && (idle_q == '0);

    case (state_q)
      ST_LOCKED: begin
        if (bus.dk) begin
          if (last_digit) begin
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            idle_d      = '0;
            if (!miss_now) begin
              state_d    = ST_UNLOCKED;
              fail_cnt_d = '0;
            end else if (({1'b0, fail_cnt_q} + 3'd1) < MAX_F) begin
              fail_cnt_d = fail_cnt_q + 2'd1;
            end else begin
              state_d    = ST_ALARM;
              fail_cnt_d = MAX_F[1:0];
              lock_d     = LOCK_LOAD;
            end
          end else begin
            digit_cnt_d = digit_cnt_q + 3'd1;
            mismatch_d  = miss_now;
            idle_d      = IDLE_LOAD;
          end
        end else if (idle_expired) begin
          digit_cnt_d = '0;
          mismatch_d  = 1'b0;
        end else if (digit_cnt_q != 3'd0) begin
          idle_d = idle_q - 1'b1;
        end
      end

      ST_ALARM: begin
        if (lock_q == '0) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = '0;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end

      ST_UNLOCKED: begin
        if (bus.relock) begin
          state_d     = ST_LOCKED;
          digit_cnt_d = '0;
          shadow_d    = '0;
          idle_d      = '0;
        end else if (bus.dk && bus.prog) begin
          if (last_digit) begin
            pw_d        = shadow_wr;
            shadow_d    = '0;
            state_d     = ST_LOCKED;
            digit_cnt_d = '0;
            idle_d      = '0;
          end else begin
            shadow_d    = shadow_wr;
            digit_cnt_d = digit_cnt_q + 3'd1;
            idle_d      = IDLE_LOAD;
          end
        end else if (idle_expired) begin
          shadow_d    = '0;
          digit_cnt_d = '0;
        end else if (digit_cnt_q != 3'd0) begin
          idle_d = idle_q - 1'b1;
        end
      end

      default: begin
        state_d     = ST_LOCKED;
        digit_cnt_d = '0;
        mismatch_d  = 1'b0;
      end
    endcase
  end

  assign bus.locked    = state_q[0];
  assign bus.unlocked  = state_q[1];
  assign bus.alarm     = state_q[2];
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_password_checker.sv
// Scenario bench for password_checker with short lockout/timeout limits.
// Status is packed as {locked, unlocked, alarm, digit_cnt[2:0], fail_cnt[1:0]}.
module tb_password_checker;
  logic clk = 1'b0;
  logic reset;

  password_checker_if #(.DIGIT_W(3)) pw_if ();

  password_checker #(
    .LOCKOUT_CYCLES(8),
    .ENTRY_TIMEOUT (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (pw_if)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] sb_q[$];
  logic [7:0] obs;
  logic [7:0] exp_st;

  localparam logic [11:0] PW_OK  = 12'b001_010_011_100;
  localparam logic [11:0] PW_BAD = 12'b001_010_011_101;
  localparam logic [11:0] PW_NEW = 12'b111_000_111_000;

  function automatic logic [7:0] st(input logic l, input logic u, input logic a,
                                    input logic [2:0] dc, input logic [1:0] fc);
    return {l, u, a, dc, fc};
  endfunction

  function automatic logic [7:0] status();
    return {pw_if.locked, pw_if.unlocked, pw_if.alarm, pw_if.digit_cnt, pw_if.fail_cnt};
  endfunction

  task automatic drive_digit(input logic [2:0] d);
    @(negedge clk);
    pw_if.data = d;
    pw_if.dk   = 1'b1;
    @(negedge clk);
    pw_if.dk   = 1'b0;
    pw_if.data = 3'd0;
  endtask

  task automatic enter_pw(input logic [11:0] pw);
    for (int i = 0; i < 4; i++) drive_digit(pw[11-3*i -: 3]);
  endtask

  task automatic do_relock();
    @(negedge clk);
    pw_if.relock = 1'b1;
    @(negedge clk);
    pw_if.relock = 1'b0;
  endtask

  task automatic test_reset();
    pw_if.data = 3'd0; pw_if.dk = 1'b0; pw_if.prog = 1'b0; pw_if.relock = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL reset_async got=%b want=%b", obs, exp_st);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL reset_release got=%b want=%b", obs, exp_st);
  endtask

  task automatic test_unlock();
    drive_digit(3'd1); drive_digit(3'd2); drive_digit(3'd3);
    @(negedge clk);
    pw_if.data = 3'd4;
    pw_if.dk   = 1'b1;
    sb_q.push_back(st(1, 0, 0, 3'd3, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL pre_final got=%b want=%b", obs, exp_st);
    @(negedge clk);
    pw_if.dk = 1'b0;
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL unlock_1cyc got=%b want=%b", obs, exp_st);
    drive_digit(3'd5);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL unl_dk_noprog got=%b want=%b", obs, exp_st);
    do_relock();
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL relock got=%b want=%b", obs, exp_st);
  endtask

  task automatic test_alarm();
    enter_pw(PW_BAD);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd1));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL fail_1 got=%b want=%b", obs, exp_st);
    enter_pw(PW_BAD);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd2));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL fail_2 got=%b want=%b", obs, exp_st);
    drive_digit(3'd1); drive_digit(3'd2);
    sb_q.push_back(st(1, 0, 0, 3'd2, 2'd2));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL partial_cnt got=%b want=%b", obs, exp_st);
    drive_digit(3'd3); drive_digit(3'd5);
    sb_q.push_back(st(1, 0, 1, 3'd0, 2'd3));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL alarm_on got=%b want=%b", obs, exp_st);
    // correct password strobed during the lockout must have no effect
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        pw_if.data = 3'(k);
        pw_if.dk   = 1'b1;
      end else begin
        pw_if.dk   = 1'b0;
        pw_if.data = 3'd0;
      end
    end
    sb_q.push_back(st(1, 0, 1, 3'd0, 2'd3));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL alarm_hold got=%b want=%b", obs, exp_st);
    @(negedge clk);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL alarm_exit got=%b want=%b", obs, exp_st);
  endtask

  task automatic test_program();
    enter_pw(PW_OK);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL unlock_for_prog got=%b want=%b", obs, exp_st);
    pw_if.prog = 1'b1;
    drive_digit(3'd7); drive_digit(3'd0);
    sb_q.push_back(st(0, 1, 0, 3'd2, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL prog_partial got=%b want=%b", obs, exp_st);
    drive_digit(3'd7); drive_digit(3'd0);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL prog_commit got=%b want=%b", obs, exp_st);
    pw_if.prog = 1'b0;
    enter_pw(PW_OK);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd1));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL old_pw_rejected got=%b want=%b", obs, exp_st);
    enter_pw(PW_NEW);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL new_pw_accepted got=%b want=%b", obs, exp_st);
  endtask

  task automatic test_reset_programmed();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL reset_unlocked got=%b want=%b", obs, exp_st);
    @(negedge clk);
    reset = 1'b1;
    enter_pw(PW_OK);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL default_pw_restored got=%b want=%b", obs, exp_st);
  endtask

  task automatic test_relock_abort();
    pw_if.prog = 1'b1;
    drive_digit(3'd5); drive_digit(3'd5);
    sb_q.push_back(st(0, 1, 0, 3'd2, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL abort_partial got=%b want=%b", obs, exp_st);
    @(negedge clk);
    pw_if.data   = 3'd3;
    pw_if.dk     = 1'b1;
    pw_if.relock = 1'b1;
    @(negedge clk);
    pw_if.dk     = 1'b0;
    pw_if.relock = 1'b0;
    pw_if.prog   = 1'b0;
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL relock_wins got=%b want=%b", obs, exp_st);
    enter_pw(PW_OK);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL pw_unchanged got=%b want=%b", obs, exp_st);
    do_relock();
  endtask

  task automatic test_timeout();
    drive_digit(3'd1); drive_digit(3'd2);
    repeat (14) @(negedge clk);
    sb_q.push_back(st(1, 0, 0, 3'd2, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL idle_14 got=%b want=%b", obs, exp_st);
    repeat (2) @(negedge clk);
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL idle_timeout got=%b want=%b", obs, exp_st);
    enter_pw(PW_OK);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL unlock_after_to got=%b want=%b", obs, exp_st);
    pw_if.prog = 1'b1;
    drive_digit(3'd6);
    repeat (16) @(negedge clk);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL prog_timeout got=%b want=%b", obs, exp_st);
    // after the discard, a full new sequence must start from digit 0
    enter_pw(PW_NEW);
    pw_if.prog = 1'b0;
    enter_pw(PW_NEW);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL prog_after_to got=%b want=%b", obs, exp_st);
    do_relock();
  endtask

  task automatic test_alarm_reset();
    enter_pw(PW_BAD); enter_pw(PW_BAD); enter_pw(PW_BAD);
    sb_q.push_back(st(1, 0, 1, 3'd0, 2'd3));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL alarm_again got=%b want=%b", obs, exp_st);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    sb_q.push_back(st(1, 0, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL reset_in_alarm got=%b want=%b", obs, exp_st);
    @(negedge clk);
    reset = 1'b1;
    enter_pw(PW_OK);
    sb_q.push_back(st(0, 1, 0, 3'd0, 2'd0));
    obs = status(); exp_st = sb_q.pop_front(); n_chk++;
    if (obs === exp_st) n_pass++; else $display("FAIL unlock_after_alarm_rst got=%b want=%b", obs, exp_st);
  endtask

  task automatic test_back_to_back();
    logic [11:0] seq [3];
    logic [7:0]  want [3];
    seq[0] = PW_OK;  want[0] = st(0, 1, 0, 3'd0, 2'd0);
    seq[1] = 12'b001_010_011_111; want[1] = st(1, 0, 0, 3'd0, 2'd1);
    seq[2] = PW_OK;  want[2] = st(0, 1, 0, 3'd0, 2'd0);
    // relock and prog held high throughout must be ignored while locked
    for (int s = 0; s < 3; s++) begin
      pw_if.prog   = 1'b1;
      pw_if.relock = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        pw_if.data = seq[s][11-3*i -: 3];
        pw_if.dk   = 1'b1;
      end
      sb_q.push_back(want[s]);
      @(negedge clk);
      pw_if.dk     = 1'b0;
      pw_if.relock = 1'b0;
      pw_if.prog   = 1'b0;
      obs = status(); exp_st = sb_q.pop_front(); n_chk++;
      if (obs === exp_st) n_pass++; else $display("FAIL b2b_seq%0d got=%b want=%b", s, obs, exp_st);
      if (pw_if.unlocked) do_relock();
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_alarm();
    test_program();
    test_reset_programmed();
    test_relock_abort();
    test_timeout();
    test_alarm_reset();
    do_relock();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench did not finish");
  end
endmodule
